range_sensor_bus_bridge: RTL

Parametrised, registered successor to the range-sensor subsystem slot decoder. It sits between the subsystem MMIO bus and N sensor slots. It decodes slot/register address fields and runs one transaction at a time through a small FSM, holding slot strobes until the slot acknowledges. It returns registered read data with a completion pulse, and flags out-of-range slots and slot timeouts as bus errors.

---
 rtl/range_sensor_bus_pkg.sv | 22 ++
 rtl/range_sensor_bus_bridge_if.sv | 27 ++
 rtl/range_sensor_bus_bridge_timer.sv | 29 ++
 rtl/range_sensor_bus_bridge.sv | 135 +++++++++++++
 4 files changed

// File: rtl/range_sensor_bus_pkg.sv
// Shared types and constants for the range-sensor bus bridge.
package range_sensor_bus_pkg;

  localparam int DEF_N_SLOTS = 4;
  localparam int DEF_REG_AW  = 3;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 15;

  // Read data returned for bad slots and timed-out reads; slice to DW.
  localparam logic [255:0] ERR_RD_DATA_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } rs_state_e;

  function automatic int slot_aw(input int n_slots);
    return (n_slots > 1) ? $clog2(n_slots) : 1;
  endfunction

endpackage

// File: rtl/range_sensor_bus_bridge_if.sv
// Upstream MMIO bus between the subsystem master and the sensor bridge.
interface range_sensor_bus_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int DW     = 32
);
  // Handshake: a request is cs_i with exactly one of wr_i/rd_i while busy_o=0;
  // it completes with a single-cycle ack_o (err_o alongside), rd_data_o holds after.
  logic              cs_i;
  logic              wr_i;
  logic              rd_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DW-1:0]     wr_data_i;
  logic [DW-1:0]     rd_data_o;
  logic              ack_o;
  logic              err_o;
  logic              busy_o;

  modport slave (
    input  cs_i, wr_i, rd_i, addr_i, wr_data_i,
    output rd_data_o, ack_o, err_o, busy_o
  );

  modport master (
    output cs_i, wr_i, rd_i, addr_i, wr_data_i,
    input  rd_data_o, ack_o, err_o, busy_o
  );
endinterface

// File: rtl/range_sensor_bus_bridge_timer.sv
// Access watchdog: counts cycles spent waiting for a slot ack.
module rs_bus_timeout_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  // Holding at LAST keeps the counter from wrapping; the FSM leaves on expiry anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                 cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/range_sensor_bus_bridge.sv
// Registered MMIO-to-slot bridge: one transaction at a time, slot strobes held
// until ack, bus error on bad slot, wr&rd collision or slot timeout.
module range_sensor_bus_bridge
  import range_sensor_bus_pkg::*;
#(
  parameter int N_SLOTS = DEF_N_SLOTS,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  range_sensor_bus_bridge_if.slave     bus,
  output logic [N_SLOTS-1:0]           slot_cs_arr_o,
  output logic [N_SLOTS-1:0]           slot_wr_arr_o,
  output logic [N_SLOTS-1:0]           slot_rd_arr_o,
  output logic [REG_AW-1:0]            slot_addr_o,
  output logic [DW-1:0]                slot_wr_data_o,
  input  logic [N_SLOTS-1:0][DW-1:0]   slot_rd_data_arr_i,
  input  logic [N_SLOTS-1:0]           slot_ack_arr_i,
  output rs_state_e                    state_o
);
  localparam int SLOT_AW = slot_aw(N_SLOTS);
  localparam logic [DW-1:0] ERR_RD = ERR_RD_DATA_MAX[DW-1:0];

  rs_state_e          state_q, state_d;
  logic [SLOT_AW-1:0] sel_q, sel_d;
  logic [REG_AW-1:0]  reg_q, reg_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rd_data_q, rd_data_d;
  logic               is_rd_q, is_rd_d;
  logic               err_q, err_d;

  logic [SLOT_AW-1:0] req_slot;
  logic               req_one, req_both, slot_ok, sel_ack, in_access, tmr_expired;

  assign req_slot  = bus.addr_i[SLOT_AW+REG_AW-1:REG_AW];
  assign req_one   = bus.cs_i && (bus.wr_i ^ bus.rd_i);
  assign req_both  = bus.cs_i && bus.wr_i && bus.rd_i;
  assign slot_ok   = ({1'b0, req_slot} < (SLOT_AW+1)'(N_SLOTS));
  assign in_access = (state_q == ACCESS);
  assign sel_ack   = slot_ack_arr_i[sel_q];

  rs_bus_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (!in_access),
    .en_i      (in_access),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    is_rd_d   = is_rd_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_one) begin
          sel_d   = req_slot;
          reg_d   = bus.addr_i[REG_AW-1:0];
          wdata_d = bus.wr_data_i;
          is_rd_d = bus.rd_i;
          if (slot_ok) begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d     = 1'b1;
            rd_data_d = ERR_RD;
            state_d   = DONE;
          end
        end else if (req_both) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      ACCESS: begin
        // An ack arriving in the expiry cycle still completes normally.
        if (sel_ack) begin
          if (is_rd_q) rd_data_d = slot_rd_data_arr_i[sel_q];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (tmr_expired) begin
          if (is_rd_q) rd_data_d = ERR_RD;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      is_rd_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      is_rd_q   <= is_rd_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    slot_cs_arr_o = '0;
    slot_wr_arr_o = '0;
    slot_rd_arr_o = '0;
    if (in_access) begin
      slot_cs_arr_o[sel_q] = 1'b1;
      slot_wr_arr_o[sel_q] = !is_rd_q;
      slot_rd_arr_o[sel_q] = is_rd_q;
    end
  end

  assign slot_addr_o    = reg_q;
  assign slot_wr_data_o = wdata_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.ack_o      = (state_q == DONE);
  assign bus.err_o      = (state_q == DONE) && err_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign state_o        = state_q;
endmodule
